// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with up/down tick, validated load and wrap pulses.
// Define BCD_CNT_LOOKAHEAD_EN to add the combinational terminal-count output tc_o.
module bcd_mod_counter #(
  parameter int MODULUS = 60,
  parameter int RST_VAL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       up_dn_i,
  input  logic       load_i,
  input  logic [3:0] load_tens_i,
  input  logic [3:0] load_ones_i,
  output logic [3:0] q_tens_o,
  output logic [3:0] q_ones_o,
  output logic       carry_o,
  output logic       borrow_o,
`ifdef BCD_CNT_LOOKAHEAD_EN
  output logic       tc_o,
`endif
  output logic       load_err_o
);

  if (MODULUS < 2 || MODULUS > 100) begin : g_bad_mod
    $error("bcd_mod_counter: MODULUS must be 2..100");
  end
  if (RST_VAL < 0 || RST_VAL >= MODULUS) begin : g_bad_rst
    $error("bcd_mod_counter: RST_VAL must be 0..MODULUS-1");
  end

  localparam int MAXV = MODULUS - 1;
  localparam logic [3:0] MAX_T = 4'(MAXV / 10);
  localparam logic [3:0] MAX_O = 4'(MAXV % 10);
  localparam logic [3:0] RST_T = 4'(RST_VAL / 10);
  localparam logic [3:0] RST_O = 4'(RST_VAL % 10);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       carry_q, carry_d;
  logic       borrow_q, borrow_d;
  logic       err_q, err_d;

  logic at_max;
  logic at_zero;
  logic load_ok;

  assign at_max  = (tens_q == MAX_T) && (ones_q == MAX_O);
  assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

  // Lexicographic digit compare avoids a binary conversion of the load value.
  assign load_ok = (load_tens_i <= 4'd9) && (load_ones_i <= 4'd9) &&
                   ((load_tens_i < MAX_T) ||
                    ((load_tens_i == MAX_T) && (load_ones_i <= MAX_O)));

  always_comb begin
    tens_d   = tens_q;
    ones_d   = ones_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    err_d    = 1'b0;
    if (load_i) begin
      if (load_ok) begin
        tens_d = load_tens_i;
        ones_d = load_ones_i;
      end else begin
        err_d = 1'b1;
      end
    end else if (tick_i) begin
      if (up_dn_i) begin
        if (at_max) begin
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          carry_d = 1'b1;
        end else if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        if (at_zero) begin
          tens_d   = MAX_T;
          ones_d   = MAX_O;
          borrow_d = 1'b1;
        end else if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tens_q   <= RST_T;
      ones_q   <= RST_O;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
    end
  end

  assign q_tens_o   = tens_q;
  assign q_ones_o   = ones_q;
  assign carry_o    = carry_q;
  assign borrow_o   = borrow_q;
  assign load_err_o = err_q;

`ifdef BCD_CNT_LOOKAHEAD_EN
  assign tc_o = up_dn_i ? at_max : at_zero;
`endif

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Directed bench for bcd_mod_counter: three instances (mod 60, 24, 100).
// Expected values are hand-computed BCD constants.
module tb_bcd_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst = '1;
  logic [2:0] tick = '0;
  logic [2:0] updn = '1;
  logic [2:0] load = '0;
  logic [3:0] lt [3];
  logic [3:0] lo [3];
  logic [3:0] qt [3];
  logic [3:0] qo [3];
  logic [2:0] cy, bw, er;
`ifdef BCD_CNT_LOOKAHEAD_EN
  logic [2:0] tc;
`endif

  int n_run = 0;
  int n_fail = 0;

  bcd_mod_counter #(.MODULUS(60), .RST_VAL(0)) u_m60 (
    .clk(clk), .rst(rst[0]), .tick_i(tick[0]), .up_dn_i(updn[0]),
    .load_i(load[0]), .load_tens_i(lt[0]), .load_ones_i(lo[0]),
    .q_tens_o(qt[0]), .q_ones_o(qo[0]),
    .carry_o(cy[0]), .borrow_o(bw[0]),
`ifdef BCD_CNT_LOOKAHEAD_EN
    .tc_o(tc[0]),
`endif
    .load_err_o(er[0])
  );

  bcd_mod_counter #(.MODULUS(24), .RST_VAL(0)) u_m24 (
    .clk(clk), .rst(rst[1]), .tick_i(tick[1]), .up_dn_i(updn[1]),
    .load_i(load[1]), .load_tens_i(lt[1]), .load_ones_i(lo[1]),
    .q_tens_o(qt[1]), .q_ones_o(qo[1]),
    .carry_o(cy[1]), .borrow_o(bw[1]),
`ifdef BCD_CNT_LOOKAHEAD_EN
    .tc_o(tc[1]),
`endif
    .load_err_o(er[1])
  );

  bcd_mod_counter #(.MODULUS(100), .RST_VAL(0)) u_m100 (
    .clk(clk), .rst(rst[2]), .tick_i(tick[2]), .up_dn_i(updn[2]),
    .load_i(load[2]), .load_tens_i(lt[2]), .load_ones_i(lo[2]),
    .q_tens_o(qt[2]), .q_ones_o(qo[2]),
    .carry_o(cy[2]), .borrow_o(bw[2]),
`ifdef BCD_CNT_LOOKAHEAD_EN
    .tc_o(tc[2]),
`endif
    .load_err_o(er[2])
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // one clock for instance d with the given inputs, then sample #1 later
  task automatic cyc(input int d, input logic r, input logic ld,
                     input logic tk, input logic ud,
                     input logic [3:0] t, input logic [3:0] o);
    rst[d]  = r;
    load[d] = ld;
    tick[d] = tk;
    updn[d] = ud;
    lt[d]   = t;
    lo[d]   = o;
    @(posedge clk);
    #1;
    rst[d]  = 1'b0;
    load[d] = 1'b0;
    tick[d] = 1'b0;
  endtask

  function automatic int val(input int d);
    return int'({qt[d], qo[d]});
  endfunction

  function automatic int pls(input int d);
    return int'({cy[d], bw[d], er[d]});
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin
      lt[i] = 4'd0;
      lo[i] = 4'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = '0;
    chk("rst60_val", val(0), 'h00);
    chk("rst60_pls", pls(0), 0);

    // mod 60: reset mid-count at 37, tick pending
    cyc(0, 0, 1, 0, 1, 4'd3, 4'd7);
    chk("ld37", val(0), 'h37);
    cyc(0, 1, 1, 1, 1, 4'd5, 4'd0);
    chk("rst_mid1", val(0), 'h00);
    chk("rst_mid1_pls", pls(0), 0);
    cyc(0, 1, 0, 1, 1, 4'd0, 4'd0);
    chk("rst_mid2", val(0), 'h00);

    // up wrap 58 -> 59 -> 00
    cyc(0, 0, 1, 0, 1, 4'd5, 4'd8);
    chk("ld58", val(0), 'h58);
    cyc(0, 0, 0, 1, 1, 4'd0, 4'd0);
    chk("up59", val(0), 'h59);
    chk("up59_cy", int'(cy[0]), 0);
    cyc(0, 0, 0, 1, 1, 4'd0, 4'd0);
    chk("wrap00", val(0), 'h00);
    chk("wrap00_cy", int'(cy[0]), 1);
    cyc(0, 0, 0, 0, 1, 4'd0, 4'd0);
    chk("hold_cy", int'(cy[0]), 0);
    chk("hold_val", val(0), 'h00);

    // 09 -> 10 digit carry
    cyc(0, 0, 1, 0, 1, 4'd0, 4'd9);
    cyc(0, 0, 0, 1, 1, 4'd0, 4'd0);
    chk("up10", val(0), 'h10);
    chk("up10_pls", pls(0), 0);

    // load/tick collision at 59
    cyc(0, 0, 1, 0, 1, 4'd5, 4'd9);
    cyc(0, 0, 1, 1, 1, 4'd1, 4'd2);
    chk("coll_val", val(0), 'h12);
    chk("coll_cy", int'(cy[0]), 0);
    cyc(0, 0, 1, 0, 1, 4'd6, 4'd0);
    chk("rej60_val", val(0), 'h12);
    chk("rej60_err", int'(er[0]), 1);

    // mod 24: down wrap, rejections
    cyc(1, 0, 1, 0, 1, 4'd0, 4'd0);
    chk("ld00", val(1), 'h00);
    cyc(1, 0, 0, 1, 0, 4'd0, 4'd0);
    chk("dn23", val(1), 'h23);
    chk("dn23_bw", int'(bw[1]), 1);
    cyc(1, 0, 0, 1, 0, 4'd0, 4'd0);
    chk("dn22", val(1), 'h22);
    chk("dn22_bw", int'(bw[1]), 0);
    cyc(1, 0, 1, 0, 1, 4'd2, 4'd4);
    chk("rej24_val", val(1), 'h22);
    chk("rej24_err", int'(er[1]), 1);
    cyc(1, 0, 1, 0, 1, 4'd1, 4'd10);
    chk("rej1a_val", val(1), 'h22);
    chk("rej1a_err", int'(er[1]), 1);
    cyc(1, 0, 1, 0, 1, 4'd2, 4'd3);
    chk("ld23", val(1), 'h23);
    chk("ld23_err", int'(er[1]), 0);
    cyc(1, 0, 0, 1, 0, 4'd0, 4'd0);
    chk("dn_20to", val(1), 'h22);
    cyc(1, 0, 1, 0, 1, 4'd1, 4'd0);
    cyc(1, 0, 0, 1, 0, 4'd0, 4'd0);
    chk("dn09", val(1), 'h09);

    // mod 100: full-range wraps
    cyc(2, 0, 1, 0, 1, 4'd9, 4'd9);
    chk("ld99", val(2), 'h99);
`ifdef BCD_CNT_LOOKAHEAD_EN
    chk("tc99_up", int'(tc[2]), 1);
    updn[2] = 1'b0;
    #1;
    chk("tc99_dn", int'(tc[2]), 0);
    updn[2] = 1'b1;
    #1;
`endif
    cyc(2, 0, 0, 1, 1, 4'd0, 4'd0);
    chk("m100_wrap", val(2), 'h00);
    chk("m100_cy", int'(cy[2]), 1);
`ifdef BCD_CNT_LOOKAHEAD_EN
    updn[2] = 1'b0;
    #1;
    chk("tc00_dn", int'(tc[2]), 1);
`endif
    cyc(2, 0, 0, 1, 0, 4'd0, 4'd0);
    chk("m100_dn99", val(2), 'h99);
    chk("m100_bw", int'(bw[2]), 1);
    chk("m100_cy0", int'(cy[2]), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
